// File: rtl/spi_controller_if.sv
// Request handshake and SPI pin bundle shared by spi_controller and its requester.
// The master modport is the requester side. The slave modport is the controller side.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, sclk, copi, ncs, busy, done
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, sclk, copi, ncs, busy, done
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: accepts one 16-bit {rw, addr, data} frame per handshake and
// shifts it out MSB-first with paced sclk, chip-select setup/hold and an idle gap.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_controller_if.slave bus
);
    // One shared down-counter times every phase, so it is sized for the largest one.
    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B   = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             copi_q, copi_d;
    logic             ncs_q, ncs_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    shreg_d = {bus.req_rw, bus.req_addr, bus.req_data};
                    copi_d  = bus.req_rw;
                    ncs_d   = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                    cnt_d   = DIV_LD;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    cnt_d  = DIV_LD;
                end else begin
                    // Falling sclk: the only point where copi may move to the next bit.
                    sclk_d = 1'b0;
                    if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                        copi_d  = shreg_q[14];
                        cnt_d   = DIV_LD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.sclk      = sclk_q;
    assign bus.copi      = copi_q;
    assign bus.ncs       = ncs_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default instance plus a fast CLK_DIV=2 instance,
// with a pin-level monitor that reconstructs frames and timing from sclk/copi/ncs.
module tb_spi_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_controller_if if_a ();
    spi_controller_if if_b ();

    spi_controller dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    spi_controller #(
        .CLK_DIV  (2),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .IDLE_GAP (2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // sel picks which instance the stimulus and the monitor talk to.
    logic sel = 1'b0;
    logic m_sclk, m_copi, m_ncs, m_done, m_ready, m_busy;
    int   cur_div;
    assign m_sclk  = sel ? if_b.sclk      : if_a.sclk;
    assign m_copi  = sel ? if_b.copi      : if_a.copi;
    assign m_ncs   = sel ? if_b.ncs       : if_a.ncs;
    assign m_done  = sel ? if_b.done      : if_a.done;
    assign m_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign m_busy  = sel ? if_b.busy      : if_a.busy;
    assign cur_div = sel ? 2 : 4;

    int n_err    = 0;
    int n_checks = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pin monitor, sampled on the falling clk edge.
    logic        p_sclk = 1'b0, p_copi = 1'b0, p_ncs = 1'b1, first_bit = 1'b1;
    logic [15:0] cap = '0;
    int edges = 0, dones = 0, phase_bad = 0, copi_bad = 0;
    int hi_run = 0, lo_run = 0, ncs_lo = 0, ncs_hi = 0;
    int last_ncs_lo = 0, last_ncs_hi = 0;
    logic [15:0] frame_log[$];

    always @(negedge clk) begin
        p_sclk <= m_sclk;
        p_copi <= m_copi;
        p_ncs  <= m_ncs;
        hi_run <= m_sclk  ? (p_sclk  ? hi_run + 1 : 1) : 0;
        lo_run <= !m_sclk ? (!p_sclk ? lo_run + 1 : 1) : 0;
        ncs_lo <= !m_ncs  ? (!p_ncs  ? ncs_lo + 1 : 1) : 0;
        ncs_hi <= m_ncs   ? (p_ncs   ? ncs_hi + 1 : 1) : 0;
        dones  <= dones + (m_done ? 1 : 0);
        if (m_sclk && !p_sclk) begin
            edges     <= edges + 1;
            cap       <= {cap[14:0], m_copi};
            first_bit <= 1'b0;
            if (!first_bit && lo_run != cur_div) phase_bad <= phase_bad + 1;
        end
        if (!m_sclk && p_sclk && hi_run != cur_div) phase_bad <= phase_bad + 1;
        if (!m_ncs && !p_ncs && (m_copi != p_copi) && !(p_sclk && !m_sclk))
            copi_bad <= copi_bad + 1;
        if (!m_ncs && p_ncs) begin
            first_bit   <= 1'b1;
            last_ncs_hi <= ncs_hi;
        end
        if (m_ncs && !p_ncs) begin
            last_ncs_lo <= ncs_lo;
            frame_log.push_back(cap);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [6:0] addr, input logic [7:0] data);
        if (sel) begin
            if_b.req_valid = v; if_b.req_rw = rw; if_b.req_addr = addr; if_b.req_data = data;
        end else begin
            if_a.req_valid = v; if_a.req_rw = rw; if_a.req_addr = addr; if_a.req_data = data;
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 3000 && !m_ready; i++) tick();
        check({tag, " ready reached"}, 32'(m_ready), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " ncs"},   32'(m_ncs),   1);
        check({tag, " sclk"},  32'(m_sclk),  0);
        check({tag, " copi"},  32'(m_copi),  0);
        check({tag, " ready"}, 32'(m_ready), 1);
        check({tag, " busy"},  32'(m_busy),  0);
        check({tag, " done"},  32'(m_done),  0);
    endtask

    // One full frame: handshake, frame content, edge count, ncs-low length, done pulse,
    // sclk phase lengths, copi stability and ready return after ncs rises.
    task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                             input logic [15:0] exp_frame, input int exp_lo, input string tag);
        int   e0, d0, pb0, cb0, n0, gap;
        logic done_first;
        wait_ready(tag);
        e0 = edges; d0 = dones; pb0 = phase_bad; cb0 = copi_bad; n0 = frame_log.size();
        drive(1'b1, rw, addr, data);
        tick();
        check({tag, " ncs low 1 cycle after accept"}, 32'(m_ncs), 0);
        check({tag, " busy/ready after accept"}, 32'({m_busy, m_ready}), 32'h2);
        drive(1'b0, ~rw, ~addr, ~data);
        for (int i = 0; i < 3000 && !m_ncs; i++) tick();
        check({tag, " ncs rises"}, 32'(m_ncs), 1);
        done_first = m_done;
        gap = 1;
        for (int i = 0; i < 100 && !m_ready; i++) begin
            tick();
            if (!m_ready) gap++;
        end
        check({tag, " done on first gap cycle"}, 32'(done_first), 1);
        check({tag, " gap cycles before ready"}, gap, 2);
        check({tag, " frames logged"}, frame_log.size() - n0, 1);
        check({tag, " frame"}, 32'(frame_log[n0]), 32'(exp_frame));
        check({tag, " rising sclk edges"}, edges - e0, 16);
        check({tag, " ncs low cycles"}, last_ncs_lo, exp_lo);
        check({tag, " done cycles"}, dones - d0, 1);
        check({tag, " sclk phase errors"}, phase_bad - pb0, 0);
        check({tag, " copi changes off falling sclk"}, copi_bad - cb0, 0);
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0, d0, n0;

        vecs[0] = '{1'b1, 7'h04, 8'h80, 16'h8480};
        vecs[1] = '{1'b0, 7'h55, 8'hA5, 16'h55A5};
        vecs[2] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF};
        vecs[3] = '{1'b0, 7'h00, 8'h00, 16'h0000};
        vecs[4] = '{1'b0, 7'h2A, 8'h3C, 16'h2A3C};
        vecs[5] = '{1'b1, 7'h2A, 8'h3C, 16'hAA3C};

        sel = 1'b0;
        drive(1'b0, 1'b0, 7'h00, 8'h00);
        sel = 1'b1;
        drive(1'b0, 1'b0, 7'h00, 8'h00);
        sel = 1'b0;

        // Power-on reset, checked before any clk edge.
        #1 rst = 1'b1;
        #1 check_reset("t1 power-on");
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_reset("t1 idle after release");
        #2 rst = 1'b1;
        #1 check_reset("t1 mid-idle async");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven frames on the default instance.
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].frame, 132,
                      $sformatf("vec%0d", i));

        // req_valid held across two queued frames.
        wait_ready("t4");
        n0 = frame_log.size();
        d0 = dones;
        drive(1'b1, 1'b1, 7'h00, 8'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_busy) break;
        end
        check("t4 first accepted", 32'(m_busy), 1);
        drive(1'b1, 1'b1, 7'h01, 8'h02);
        for (int i = 0; i < 3000 && !m_ready; i++) tick();
        check("t4 idle between frames", 32'(m_ready), 1);
        tick();
        check("t4 second accepted on first idle cycle", 32'(m_busy), 1);
        drive(1'b0, 1'b0, 7'h00, 8'h00);
        wait_ready("t4 end");
        repeat (10) tick();
        check("t4 frames logged", frame_log.size() - n0, 2);
        check("t4 frame 0", 32'(frame_log[n0]), 32'h8001);
        check("t4 frame 1", 32'(frame_log[n0 + 1]), 32'h8102);
        check("t4 ncs high between frames", last_ncs_hi, 3);
        check("t4 done cycles", dones - d0, 2);

        // Reset after the 7th rising sclk edge, then a clean frame.
        wait_ready("t5");
        e0 = edges;
        d0 = dones;
        drive(1'b1, 1'b1, 7'h7F, 8'hFF);
        tick();
        drive(1'b0, 1'b0, 7'h00, 8'h00);
        for (int i = 0; i < 2000 && (edges - e0) < 7; i++) tick();
        check("t5 reached 7 edges", edges - e0, 7);
        check("t5 copi high before reset", 32'(m_copi), 1);
        #1 rst = 1'b1;
        #1 check_reset("t5 mid-frame async");
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("t5 no done after abort", dones - d0, 0);
        run_frame(1'b1, 7'h00, 8'hAA, 16'h80AA, 132, "t5 post-reset");

        // Fast instance: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1.
        repeat (2) tick();
        sel = 1'b1;
        repeat (2) tick();
        run_frame(1'b1, 7'h04, 8'h80, 16'h8480, 66, "t6 fast");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
